// File: rtl/audio_nios_pulse_out_pio.sv
// audio_nios_pulse_out_pio
//
// Avalon-MM slave output PIO with atomic set/clear and a hardware one-shot.
// Software writes a level register (DATA) or sets/clears individual bits
// (OUTSET/OUTCLR). A PULSE write holds the selected bits high for PLEN clocks,
// so short strobes such as codec reset or SD power-cycle need no CPU timing.
//
// Word map: 0 DATA (rw), 2 PLEN (rw), 3 PULSE (w: trigger, r: remaining count),
//           4 OUTSET (w), 5 OUTCLR (w), 1/6/7 reserved (read 0).
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   address     register word select
//   chipselect  slave select (writes only; reads ignore it)
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, one cycle latency
//   out_port    driven pins, data | pulse mask
module audio_nios_pulse_out_pio #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    CNT_WIDTH   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] pmask;
  logic [CNT_WIDTH-1:0]  plen;
  logic [CNT_WIDTH-1:0]  count;
  logic [31:0]           rd_mux;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;

  assign wr = chipselect && !write_n;
  assign wd = writedata[DATA_WIDTH-1:0];

  logic unused_wd;
  assign unused_wd = ^writedata[31:CNT_WIDTH];

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux[DATA_WIDTH-1:0] = data;
      3'd2:    rd_mux[CNT_WIDTH-1:0]  = plen;
      3'd3:    rd_mux[CNT_WIDTH-1:0]  = count;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data     <= RESET_VALUE;
      plen     <= '0;
      count    <= '0;
      pmask    <= '0;
      readdata <= '0;
    end else begin
      readdata <= rd_mux;

      if (wr) begin
        case (address)
          3'd0:    data <= wd;
          3'd2:    plen <= writedata[CNT_WIDTH-1:0];
          3'd4:    data <= data | wd;
          3'd5:    data <= data & ~wd;
          default: ;
        endcase
      end

      // A valid trigger reloads and replaces the mask; it takes priority over
      // the countdown so the reload edge does not also decrement.
      if (wr && address == 3'd3 && plen != '0) begin
        count <= plen;
        pmask <= wd;
      end else if (count > CNT_ONE) begin
        count <= count - CNT_ONE;
      end else if (count == CNT_ONE) begin
        count <= '0;
        pmask <= '0;
      end
    end
  end

  assign out_port = data | pmask;

endmodule
